toggle_event_arbiter: RTL
=========================

# toggle_event_arbiter

Source-domain scheduler that shares one toggle-based pulse synchronizer channel between `N_REQ` event requesters. It latches request pulses as pending flags, grants them in round-robin order and launches each one as a `src_toggle` flip with a stable `src_id`. It then waits for the returned acknowledge toggle before launching the next event. The block sits in the source clock domain, in front of the forward pulse_sync (toggle + id) and behind a reverse pulse_sync that carries the ack toggle back.

## Interface
- `N_REQ`, 4: number of requesters, range 2..32.
- `ID_W`, `$clog2(N_REQ)`: width of `src_id`; derived, do not override.
- `TIMEOUT`, 1024: maximum cycles in WAIT_ACK before error; 0 disables the timeout.
- `RST_VAL`, 1'b0: reset level of `src_toggle`; must match the RST_VAL of the far-side synchronizers.

Ports:
- `src_clk` in 1: the only clock.
- `src_rst` in 1: reset, synchronous, active-high.
- `src_req` in N_REQ: per-requester single-cycle event pulses.
- `src_ack_toggle` in 1: acknowledge toggle, already synchronized into `src_clk`.
- `src_err_clr` in 1: pulse that clears the error state.
- `src_toggle` out 1: forward event toggle, registered.
- `src_id` out ID_W: index of the launched requester, registered; stable while busy.
- `src_busy` out 1: high in WAIT_ACK.
- `src_pending` out N_REQ: current pending flags.
- `src_overflow` out N_REQ: one-cycle pulse when a request hits an already-pending flag.
- `src_err` out 1: sticky ack-timeout error.

## Operation
- Reset (`src_rst` high at an edge): `src_toggle`=RST_VAL, `src_id`=0, `src_pending`=0, `src_overflow`=0, `src_busy`=0, `src_err`=0. State goes to IDLE, RR pointer to 0, timeout counter to 0. Reset overrides all other inputs.
- Pending flags: `src_req[i]` sampled at an edge sets `pending[i]`.
  - If `pending[i]` is already set and is not granted on that edge, the request is dropped and `src_overflow[i]` pulses for one cycle.
  - If `src_req[i]` coincides with the grant of `i`, the flag stays set (new event). No overflow.
- States:
  - **IDLE**: if any flag is pending, grant the first pending index searching from `ptr` upward with wrap. At that edge:
    - `src_toggle` inverts.
    - `src_id` = grant index.
    - `pending[grant]` clears.
    - `ptr` = grant+1 mod N_REQ.
    - Timeout counter clears; go to WAIT_ACK.
    - If nothing is pending, stay in IDLE.
  - **WAIT_ACK**: the ack is complete when `src_ack_toggle == src_toggle`; go to IDLE on the next edge.
    - Otherwise the counter increments.
    - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without an ack, go to ERROR and set `src_err`.
    - Ack and timeout on the same cycle: ack wins.
  - **ERROR**: no grants; pending flags and overflow still operate.
    - `src_err_clr` sets `src_toggle` = `src_ack_toggle` (realign), clears `src_err` and goes to IDLE.
    - `src_err_clr` is for recovery after a remote reset; a realign flip may produce one stray far-side pulse, and this is accepted.
- `src_err_clr` outside ERROR is ignored.
- `src_id` and `src_toggle` change only on a grant or an error clear.

## Timing
- `src_req[i]` at edge k: `pending[i]`=1 after k. Grant at k+1: toggle flips and `src_busy`=1 after k+1.
- Ack level match sampled at edge j: IDLE after j, earliest next grant at j+1. Minimum spacing between launches is therefore 2 cycles plus the round-trip ack latency.
- Timeout: with no ack, ERROR is entered TIMEOUT cycles after the grant edge.
- Fairness: a continuously pending requester waits at most N_REQ-1 other grants.

## Test plan
- Reset, then `src_req`=4'b0001 for one cycle. Required: toggle flips from 0 to 1 two edges later, `src_id`=0, `src_busy`=1. Drive ack to 1 → busy drops one cycle later.
- `src_req`=4'b1111 in one cycle with immediate ack loopback. Required: grants in order 0,1,2,3 and 4 toggle flips; then pointer 0. A further request on 2 alone grants 2.
- Two `src_req[1]` pulses while flag 1 is pending and not granted. Required: one launch and one `src_overflow[1]` pulse. A `src_req[1]` on the grant edge of 1 → flag stays set, second launch, no overflow.
- TIMEOUT=8, ack withheld. Required: `src_err`=1 8 cycles after the grant, no further flips while new requests pend. `src_err_clr` → toggle = ack level, err=0, pending grants resume.
- Ack arriving on the same cycle the counter hits TIMEOUT-1. Required: IDLE, `src_err` stays 0.
- `src_rst` asserted in WAIT_ACK with 3 flags pending. Required: all outputs at reset values after that edge, `src_toggle`=RST_VAL, no grant until a new request.

Source files
------------

// File: rtl/toggle_event_arbiter.sv
// Purpose : round-robin scheduler sharing one toggle+id pulse-sync channel among N_REQ event sources.
// Latency : request edge k -> pending after k, launch (toggle flip) at k+1; next launch one edge after ack match.
// Backpres: one event in flight; further requests wait as pending flags, repeats on a pending flag are dropped (src_overflow).
//
// Ports:
//   src_clk, src_rst      - clock, synchronous active-high reset
//   src_req[N_REQ]        - single-cycle event pulses from requesters
//   src_ack_toggle        - returned ack toggle, already in src_clk domain
//   src_err_clr           - clears the ack-timeout error (only acted on in ERROR)
//   src_toggle, src_id    - forward event toggle and launched requester index (registered)
//   src_busy              - an event is in flight, waiting for its ack
//   src_pending           - pending flags
//   src_overflow          - one-cycle pulse per requester whose event was dropped
//   src_err               - sticky ack-timeout error
module toggle_event_arbiter #(
    parameter int   N_REQ   = 4,
    parameter int   ID_W    = $clog2(N_REQ),
    parameter int   TIMEOUT = 1024,
    parameter logic RST_VAL = 1'b0
) (
    input  logic              src_clk,
    input  logic              src_rst,
    input  logic [N_REQ-1:0]  src_req,
    input  logic              src_ack_toggle,
    input  logic              src_err_clr,
    output logic              src_toggle,
    output logic [ID_W-1:0]   src_id,
    output logic              src_busy,
    output logic [N_REQ-1:0]  src_pending,
    output logic [N_REQ-1:0]  src_overflow,
    output logic              src_err
);

    // The counter only ever has to hold values up to TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [ID_W-1:0]  IDX_LAST = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     ptr;
    logic [CNT_W-1:0]    cnt;

    logic                grant_vld;
    logic [ID_W-1:0]     grant_idx;
    logic [N_REQ-1:0]    grant_mask;
    logic [N_REQ-1:0]    pend_nxt;
    logic [N_REQ-1:0]    ovf_nxt;
    int                  idx;
    logic [ID_W-1:0]     cand;

    // First pending flag at or above ptr, wrapping around.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = ID_W'(idx);
            if (!grant_vld && src_pending[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // A request landing on the flag being granted this edge is a fresh event,
    // so it re-arms the flag instead of counting as an overflow.
    always_comb begin
        grant_mask = '0;
        if (state == IDLE && grant_vld) begin
            grant_mask[grant_idx] = 1'b1;
        end
        ovf_nxt  = src_req & src_pending & ~grant_mask;
        pend_nxt = (src_pending & ~grant_mask) | src_req;
    end

    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            state        <= IDLE;
            ptr          <= '0;
            cnt          <= '0;
            src_toggle   <= RST_VAL;
            src_id       <= '0;
            src_busy     <= 1'b0;
            src_pending  <= '0;
            src_overflow <= '0;
            src_err      <= 1'b0;
        end else begin
            src_pending  <= pend_nxt;
            src_overflow <= ovf_nxt;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        src_toggle <= ~src_toggle;
                        src_id     <= grant_idx;
                        ptr        <= (grant_idx == IDX_LAST) ? '0 : grant_idx + ID_W'(1);
                        cnt        <= '0;
                        src_busy   <= 1'b1;
                        state      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // Ack is checked first so it wins over a same-cycle timeout.
                    if (src_ack_toggle == src_toggle) begin
                        src_busy <= 1'b0;
                        state    <= IDLE;
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        src_busy <= 1'b0;
                        src_err  <= 1'b1;
                        state    <= ERROR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ERROR: begin
                    // Realign to the far side's level; a single stray far pulse is tolerated.
                    if (src_err_clr) begin
                        src_toggle <= src_ack_toggle;
                        src_err    <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
